// File: rtl/rst_sequencer.sv
// Board-level reset sequencer.
// Synchronises and debounces the active-low reset button and the MMCM lock
// flag, then releases the peripheral reset first and the SoC external reset
// STAGE_CYCLES later. Losing either condition re-asserts both resets at once.
module rst_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int LOCK_CYCLES     = 256,
    parameter int STAGE_CYCLES    = 64,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_rst_n,
    input  logic       mmcm_locked,
    output logic       periph_reset,
    output logic       soc_erst_n,
    output logic       rst_done,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        WAIT_LOCK  = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_s;
    logic             lock_meta;
    logic             lock_s;
    logic             btn_db;
    logic [CNT_W-1:0] db_cnt;
    logic             ok;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Two-flop synchronisers for the asynchronous button and lock inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            btn_meta  <= btn_rst_n;
            btn_s     <= btn_meta;
            lock_meta <= mmcm_locked;
            lock_s    <= lock_meta;
        end
    end

    // Debounce: accept a new button level only after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign ok = btn_db & lock_s;

    // Next-state and shared counter; loss of ok wins over count completion.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            HOLD: begin
                cnt_next = '0;
                if (ok) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (!ok) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_next = REL_PERIPH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            REL_PERIPH: begin
                if (!ok) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else if (cnt == STAGE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!ok) state_next = HOLD;
            end
            default: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and outputs registered together; outputs decode the
    // next state so they change on the same edge as state_o, glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HOLD;
            cnt          <= '0;
            periph_reset <= 1'b1;
            soc_erst_n   <= 1'b0;
            rst_done     <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            periph_reset <= (state_next == HOLD) || (state_next == WAIT_LOCK);
            soc_erst_n   <= (state_next == RUN);
            rst_done     <= (state_next == RUN);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer with small parameters. The reference model tracks
// the sequence as "how many consecutive edges has the system been ok", and
// derives the phase from that run length.
module tb_rst_sequencer;

    localparam int DEB   = 4;
    localparam int LOCK  = 8;
    localparam int STAGE = 4;
    localparam int RUN_CAP = LOCK + STAGE + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_rst_n;
    logic       mmcm_locked;
    logic       periph_reset;
    logic       soc_erst_n;
    logic       rst_done;
    logic [1:0] state_o;

    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // model state
    logic m_b1, m_b2, m_l1, m_l2, m_db;
    int   m_mis;
    int   m_run;

    rst_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCK_CYCLES(LOCK),
        .STAGE_CYCLES(STAGE),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_rst_n(btn_rst_n),
        .mmcm_locked(mmcm_locked),
        .periph_reset(periph_reset),
        .soc_erst_n(soc_erst_n),
        .rst_done(rst_done),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs applied before it.
    task automatic model_edge(input logic rst, input logic btn, input logic lck);
        logic ok_now;
        if (rst) begin
            m_b1 = 0; m_b2 = 0; m_l1 = 0; m_l2 = 0;
            m_db = 0; m_mis = 0; m_run = 0;
        end else begin
            ok_now = m_db & m_l2;
            if (ok_now) m_run = (m_run < RUN_CAP) ? m_run + 1 : m_run;
            else        m_run = 0;
            if (m_b2 != m_db) begin
                m_mis = m_mis + 1;
                if (m_mis == DEB) begin
                    m_db  = m_b2;
                    m_mis = 0;
                end
            end else begin
                m_mis = 0;
            end
            m_b2 = m_b1; m_b1 = btn;
            m_l2 = m_l1; m_l1 = lck;
        end
    endtask

    // Phase follows directly from the ok run length.
    function automatic logic [4:0] model_outputs();
        logic [1:0] ph;
        if (m_run == 0)                 ph = 2'd0;
        else if (m_run <= LOCK)         ph = 2'd1;
        else if (m_run <= LOCK + STAGE) ph = 2'd2;
        else                            ph = 2'd3;
        return {ph, (ph < 2'd2), (ph == 2'd3), (ph == 2'd3)};
    endfunction

    // driver: apply inputs, predict the result of the coming edge, wait it out
    task automatic step(input logic rst, input logic btn, input logic lck);
        reset       = rst;
        btn_rst_n   = btn;
        mmcm_locked = lck;
        model_edge(rst, btn, lck);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic btn, input logic lck);
        for (int i = 0; i < n; i++) step(1'b0, btn, lck);
    endtask

    // scoreboard monitor
    initial begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {state_o, periph_reset, soc_erst_n, rst_done};
                n_checks++;
                if (act_v === exp_v) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t state/periph/erst_n/done got %0d/%b/%b/%b want %0d/%b/%b/%b",
                             $time, act_v[4:3], act_v[2], act_v[1], act_v[0],
                             exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        int guard;
        int len;
        int kind;
        logic b, l;

        // power-on reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);

        // full release sequence, then settle in RUN
        steps(25, 1'b1, 1'b1);

        // short press is filtered out
        steps(3, 1'b0, 1'b1);
        steps(10, 1'b1, 1'b1);

        // held press drops both resets, release repeats the sequence
        steps(12, 1'b0, 1'b1);
        steps(25, 1'b1, 1'b1);

        // lock loss to HOLD, then a one-cycle glitch mid WAIT_LOCK (cnt=5)
        steps(10, 1'b1, 1'b0);
        guard = 0;
        while (m_run != 6 && guard < 100) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        step(1'b0, 1'b1, 1'b0);
        steps(25, 1'b1, 1'b1);

        // bouncing button while held in HOLD
        steps(10, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 1'b1);
        steps(25, 1'b1, 1'b1);

        // reset in REL_PERIPH at cnt=2
        steps(10, 1'b0, 1'b1);
        guard = 0;
        while (m_run != LOCK + 3 && guard < 100) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        step(1'b1, 1'b1, 1'b1);
        steps(25, 1'b1, 1'b1);

        // randomized segments
        for (int seg = 0; seg < 150; seg++) begin
            len  = $urandom_range(1, 40);
            kind = $urandom_range(0, 9);
            b    = ($urandom_range(0, 3) != 0);
            l    = ($urandom_range(0, 4) != 0);
            if (kind == 0) begin
                for (int i = 0; i < (len % 3) + 1; i++) step(1'b1, b, l);
            end else if (kind <= 2) begin
                for (int i = 0; i < len; i++) step(1'b0, 1'($urandom_range(0, 1)), l);
            end else begin
                steps(len, b, l);
            end
        end

        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain left %0d entries want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
